frame_line_buffer: RTL and testbench

FRAME_LINE_BUFFER -- requirements
Module: frame_line_buffer

---
 rtl/frame_line_buffer_if.sv | 32 +++
 rtl/frame_line_buffer.sv | 181 ++++++++++++++++++
 tb/tb_frame_line_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_line_buffer_if.sv
// -----------------------------------------------------------------------------
// frame_line_buffer_if
// Purpose : bundles the incoming pixel stream and the single-port SRAM bus
//           used by frame_line_buffer.
// Signals : rx_valid/rx_data/rx_ready - pixel stream, transfer on valid&ready
//           spram_addr/spram_wr_data/spram_wre - SRAM address and write port
//           spram_rd_data - SRAM read data (returns RD_LAT cycles after addr)
// Modports: slave  - the line buffer (consumes stream, drives SRAM bus)
//           master - the environment (produces stream, models the SRAM)
// -----------------------------------------------------------------------------
interface frame_line_buffer_if #(
  parameter int PIX_W = 12,
  parameter int AW    = 15
);
  logic             rx_valid;
  logic [PIX_W-1:0] rx_data;
  logic             rx_ready;
  logic [AW-1:0]    spram_addr;
  logic [PIX_W-1:0] spram_wr_data;
  logic             spram_wre;
  logic [PIX_W-1:0] spram_rd_data;

  modport slave (
    input  rx_valid, rx_data, spram_rd_data,
    output rx_ready, spram_addr, spram_wr_data, spram_wre
  );

  modport master (
    output rx_valid, rx_data, spram_rd_data,
    input  rx_ready, spram_addr, spram_wr_data, spram_wre
  );
endinterface

// File: rtl/frame_line_buffer.sv
// -----------------------------------------------------------------------------
// frame_line_buffer
// Purpose : receives a W x H image into an external single-port SRAM, then
//           serves display pixels from a ping-pong pair of line buffers. Each
//           row_req prefetches the next display row into the back buffer while
//           the front buffer keeps feeding the display.
// Ports   : clk, rst          - single clock, synchronous active-high reset
//           state             - system mode (01 idle, 02 receive, 03 display)
//           bus               - pixel stream + SRAM bus (frame_line_buffer_if)
//           x_addr, y_addr    - current display coordinates
//           row_req           - pulse: prefetch the row for y_addr+1
//           pixel_data/valid  - registered display pixel
//           image_receiving, image_complete, row_busy, err_overflow - status
// -----------------------------------------------------------------------------
module frame_line_buffer #(
  parameter int               W        = 200,
  parameter int               H        = 150,
  parameter int               PIX_W    = 12,
  parameter int               STARTROW = 0,
  parameter int               STARTCOL = 0,
  parameter int               RD_LAT   = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           state,
  frame_line_buffer_if.slave   bus,
  input  logic [9:0]           x_addr,
  input  logic [9:0]           y_addr,
  input  logic                 row_req,
  output logic [PIX_W-1:0]     pixel_data,
  output logic                 pixel_valid,
  output logic                 image_receiving,
  output logic                 image_complete,
  output logic                 row_busy,
  output logic                 err_overflow
);

  localparam int               AW        = $clog2(W*H);
  localparam int               CW        = $clog2(W);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(W*H-1);
  localparam logic [AW-1:0]    W_A       = AW'(W);
  localparam logic [11:0]      ROW_LO    = 12'(STARTROW);
  localparam logic [11:0]      COL_LO    = 12'(STARTCOL);
  localparam logic [11:0]      H_V       = 12'(H);
  localparam logic [11:0]      W_V       = 12'(W);
  localparam logic [10:0]      FILL_LAST = 11'(W+RD_LAT-1);
  localparam logic [10:0]      W_M1      = 11'(W-1);
  localparam logic [10:0]      RD_LAT_V  = 11'(RD_LAT);

  typedef enum logic [2:0] {IDLE, RECV, DONE, DISP, FILL} fsm_t;

  fsm_t             fsm_state;
  fsm_t             fsm_next;
  logic [AW-1:0]    wr_cnt;
  logic [10:0]      fill_cnt;
  logic             front_sel;
  logic [1:0]       buf_valid;
  logic [PIX_W-1:0] line_buf [2][W];

  logic        mode_idle, mode_recv, mode_disp;
  logic        accept, last_pix, take_row, fill_done;
  logic [11:0] row_rel, col_rel, win_rel;
  logic        row_ok, col_ok, win_ok;
  logic [AW-1:0] row_base;

  assign mode_idle = (state == 8'h01);
  assign mode_recv = (state == 8'h02);
  assign mode_disp = (state == 8'h03);

  assign bus.rx_ready    = (fsm_state == RECV);
  assign image_receiving = (fsm_state == RECV);
  assign row_busy        = (fsm_state == FILL);

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign last_pix = (wr_cnt == LAST_ADDR);

  // Window tests use a 12-bit difference: a coordinate below the window start
  // wraps to a huge value, so a single "< size" test covers both bounds.
  assign row_rel  = {2'b00, y_addr} + 12'd1 - ROW_LO;
  assign row_ok   = (row_rel < H_V);
  assign win_rel  = {2'b00, y_addr} - ROW_LO;
  assign win_ok   = (win_rel < H_V);
  assign col_rel  = {2'b00, x_addr} - COL_LO;
  assign col_ok   = (col_rel < W_V);
  assign row_base = AW'(row_rel) * W_A;

  assign take_row  = (fsm_state == DISP) && mode_disp && row_req && row_ok;
  assign fill_done = (fsm_state == FILL) && mode_disp && (fill_cnt == FILL_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) fsm_state <= IDLE;
    else     fsm_state <= fsm_next;
  end

  // Next-state logic. Idle mode wins from anywhere; leaving display mode
  // mid-fill falls back to DONE so the stored image can be shown again later.
  always_comb begin
    fsm_next = fsm_state;
    if (mode_idle) begin
      fsm_next = IDLE;
    end else begin
      case (fsm_state)
        IDLE:    if (mode_recv) fsm_next = RECV;
        RECV:    if (accept && last_pix) fsm_next = DONE;
        DONE:    if (mode_disp) fsm_next = DISP;
        DISP:    if (!mode_disp) fsm_next = DONE;
                 else if (take_row) fsm_next = FILL;
        FILL:    if (!mode_disp) fsm_next = DONE;
                 else if (fill_done) fsm_next = DISP;
        default: fsm_next = IDLE;
      endcase
    end
  end

  // Datapath and status registers: SRAM write/read address sequencing, fill
  // counting, ping-pong swap and the registered display pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt            <= '0;
      fill_cnt          <= '0;
      bus.spram_addr    <= '0;
      bus.spram_wr_data <= '0;
      bus.spram_wre     <= 1'b0;
      image_complete    <= 1'b0;
      err_overflow      <= 1'b0;
      front_sel         <= 1'b0;
      buf_valid         <= 2'b00;
      pixel_data        <= BG_COLOR;
      pixel_valid       <= 1'b0;
    end else begin
      bus.spram_wre <= 1'b0;
      if (accept) begin
        bus.spram_wre     <= 1'b1;
        bus.spram_addr    <= wr_cnt;
        bus.spram_wr_data <= bus.rx_data;
        wr_cnt            <= last_pix ? '0 : wr_cnt + 1'b1;
        if (last_pix) image_complete <= 1'b1;
      end
      if ((fsm_state == DONE) && mode_recv && bus.rx_valid) err_overflow <= 1'b1;
      if (take_row) begin
        bus.spram_addr       <= row_base;
        fill_cnt             <= '0;
        buf_valid[~front_sel] <= 1'b0;
      end
      if (fsm_state == FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_cnt < W_M1) bus.spram_addr <= bus.spram_addr + 1'b1;
        if (fill_done) begin
          front_sel             <= ~front_sel;
          buf_valid[~front_sel] <= 1'b1;
        end
      end
      if (buf_valid[front_sel] && win_ok && col_ok) begin
        pixel_data  <= line_buf[front_sel][CW'(col_rel)];
        pixel_valid <= 1'b1;
      end else begin
        pixel_data  <= BG_COLOR;
        pixel_valid <= 1'b0;
      end
      if (mode_idle) begin
        wr_cnt         <= '0;
        fill_cnt       <= '0;
        buf_valid      <= 2'b00;
        image_complete <= 1'b0;
        err_overflow   <= 1'b0;
      end
    end
  end

  // Line buffer contents need no reset: they are only ever read while the
  // matching valid flag is set. Read data for the address issued at fill
  // count k arrives at fill count k+RD_LAT and lands in the back buffer.
  always_ff @(posedge clk) begin
    if ((fsm_state == FILL) && (fill_cnt >= RD_LAT_V)) begin
      line_buf[~front_sel][CW'(fill_cnt - RD_LAT_V)] <= bus.spram_rd_data;
    end
  end

endmodule

// File: tb/tb_frame_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_frame_line_buffer
// Purpose : self-checking bench for frame_line_buffer with W=4, H=3,
//           RD_LAT=2, STARTROW=10, STARTCOL=20. Models the SRAM, keeps a write
//           scoreboard and a display-pixel scoreboard.
// -----------------------------------------------------------------------------
module tb_frame_line_buffer;

  localparam int          W        = 4;
  localparam int          H        = 3;
  localparam int          PIX_W    = 12;
  localparam int          STARTROW = 10;
  localparam int          STARTCOL = 20;
  localparam int          RD_LAT   = 2;
  localparam logic [11:0] BG       = 12'h000;
  localparam int          AW       = $clog2(W*H);

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       state;
  logic [9:0]       x_addr, y_addr;
  logic             row_req;
  logic [PIX_W-1:0] pixel_data;
  logic             pixel_valid, image_receiving, image_complete, row_busy, err_overflow;

  frame_line_buffer_if #(.PIX_W(PIX_W), .AW(AW)) bus ();

  frame_line_buffer #(
    .W(W), .H(H), .PIX_W(PIX_W), .STARTROW(STARTROW), .STARTCOL(STARTCOL),
    .RD_LAT(RD_LAT), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .bus(bus),
    .x_addr(x_addr), .y_addr(y_addr), .row_req(row_req),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .image_receiving(image_receiving), .image_complete(image_complete),
    .row_busy(row_busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, read data delayed RD_LAT cycles.
  logic [PIX_W-1:0] mem [W*H];
  logic [PIX_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bus.spram_wre === 1'b1) mem[bus.spram_addr] <= bus.spram_wr_data;
    rd_pipe[0] <= mem[bus.spram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.spram_rd_data = rd_pipe[RD_LAT-1];

  typedef struct { logic [AW-1:0] addr; logic [PIX_W-1:0] data; } wr_t;
  typedef struct { logic valid; logic [PIX_W-1:0] data; } px_t;
  wr_t wr_q [$];
  px_t px_q [$];
  int  tests = 0;
  int  fails = 0;

  // Write scoreboard: every SRAM write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.spram_wre === 1'b1) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL spram_write unexpected: addr=%0d data=%h, required no write",
                 bus.spram_addr, bus.spram_wr_data);
      end else begin
        e = wr_q.pop_front();
        if (bus.spram_addr !== e.addr || bus.spram_wr_data !== e.data) begin
          fails++;
          $display("[TB] FAIL spram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.spram_addr, bus.spram_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; state = 8'h00; x_addr = '0; y_addr = '0; row_req = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    tick(); tick();
    tests++;
    if ({bus.rx_ready, bus.spram_wre, row_busy, image_receiving, image_complete,
         err_overflow, pixel_valid} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got %b, required 0000000",
               {bus.rx_ready, bus.spram_wre, row_busy, image_receiving, image_complete,
                err_overflow, pixel_valid});
    end
    tests++;
    if (pixel_data !== BG) begin
      fails++; $display("[TB] FAIL reset_pixel: got %h, required %h", pixel_data, BG);
    end
    tests++;
    if (bus.spram_addr !== '0 || bus.spram_wr_data !== '0) begin
      fails++;
      $display("[TB] FAIL reset_spram: got addr=%0d data=%h, required 0/0",
               bus.spram_addr, bus.spram_wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_receive();
    state = 8'h01; tick();
    state = 8'h02; tick();
    tests++;
    if (bus.rx_ready !== 1'b1 || image_receiving !== 1'b1) begin
      fails++;
      $display("[TB] FAIL recv_entry: got rx_ready=%b receiving=%b, required 1/1",
               bus.rx_ready, image_receiving);
    end
    for (int i = 0; i < W*H; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = PIX_W'(i + 1);
      wr_q.push_back('{addr: AW'(i), data: PIX_W'(i + 1)});
      tick();
    end
    bus.rx_valid = 1'b0;
    tests++;
    if (image_complete !== 1'b1 || bus.rx_ready !== 1'b0 || image_receiving !== 1'b0) begin
      fails++;
      $display("[TB] FAIL recv_done: got complete=%b rx_ready=%b receiving=%b, required 1/0/0",
               image_complete, bus.rx_ready, image_receiving);
    end
  endtask

  task automatic test_overflow();
    bus.rx_valid = 1'b1; bus.rx_data = 12'h00D;
    tick();
    bus.rx_valid = 1'b0;
    tests++;
    if (err_overflow !== 1'b1 || bus.spram_wre !== 1'b0) begin
      fails++;
      $display("[TB] FAIL overflow: got err=%b wre=%b, required 1/0", err_overflow, bus.spram_wre);
    end
    tick();
    tests++;
    if (wr_q.size() != 0 || err_overflow !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overflow_after: got pending_writes=%0d err=%b, required 0/1",
               wr_q.size(), err_overflow);
    end
  endtask

  task automatic test_fill();
    int n;
    px_t e;
    state = 8'h03; tick();
    y_addr = 10'd10; row_req = 1'b1; tick();
    row_req = 1'b0;
    n = 0;
    while (row_busy === 1'b1 && n < 20) begin
      if (n < W) begin
        tests++;
        if (bus.spram_addr !== AW'(W + n) || bus.spram_wre !== 1'b0) begin
          fails++;
          $display("[TB] FAIL fill_addr[%0d]: got addr=%0d wre=%b, required %0d/0",
                   n, bus.spram_addr, bus.spram_wre, W + n);
        end
      end
      n++;
      tick();
    end
    tests++;
    if (n != W + RD_LAT) begin
      fails++; $display("[TB] FAIL fill_busy_len: got %0d cycles, required %0d", n, W + RD_LAT);
    end
    y_addr = 10'd11;
    for (int i = 0; i < W; i++) begin
      x_addr = 10'(STARTCOL + i);
      px_q.push_back('{valid: 1'b1, data: PIX_W'(W + 1 + i)});
      tick();
      e = px_q.pop_front();
      tests++;
      if (pixel_valid !== e.valid || pixel_data !== e.data) begin
        fails++;
        $display("[TB] FAIL fill_pixel x=%0d: got %b/%h, required %b/%h",
                 x_addr, pixel_valid, pixel_data, e.valid, e.data);
      end
    end
  endtask

  task automatic test_out_of_range();
    int xs [5] = '{19, 24, 20, 20, 23};
    int ys [5] = '{11, 11, 13, 9, 11};
    px_t e;
    y_addr = 10'd12; row_req = 1'b1; tick();
    row_req = 1'b0;
    tests++;
    if (row_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL range_high: got row_busy=%b, required 0", row_busy);
    end
    y_addr = 10'd8; row_req = 1'b1; tick();
    row_req = 1'b0;
    tests++;
    if (row_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL range_low: got row_busy=%b, required 0", row_busy);
    end
    for (int i = 0; i < 5; i++) begin
      x_addr = 10'(xs[i]); y_addr = 10'(ys[i]);
      if (i == 4) px_q.push_back('{valid: 1'b1, data: PIX_W'(8)});
      else        px_q.push_back('{valid: 1'b0, data: BG});
      tick();
      e = px_q.pop_front();
      tests++;
      if (pixel_valid !== e.valid || pixel_data !== e.data) begin
        fails++;
        $display("[TB] FAIL window_pixel x=%0d y=%0d: got %b/%h, required %b/%h",
                 xs[i], ys[i], pixel_valid, pixel_data, e.valid, e.data);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    px_t e;
    y_addr = 10'd11; row_req = 1'b1; tick();
    row_req = 1'b0;
    n = 0;
    while (row_busy === 1'b1 && n < 20) begin
      row_req = (n == 1);
      if (n == 1) y_addr = 10'd9;
      n++;
      tick();
    end
    row_req = 1'b0;
    tests++;
    if (n != W + RD_LAT) begin
      fails++; $display("[TB] FAIL busy_len: got %0d cycles, required %0d", n, W + RD_LAT);
    end
    tick();
    tests++;
    if (row_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL busy_ignored: got row_busy=%b, required 0", row_busy);
    end
    y_addr = 10'd12;
    for (int i = 0; i < W; i++) begin
      x_addr = 10'(STARTCOL + i);
      px_q.push_back('{valid: 1'b1, data: PIX_W'(2*W + 1 + i)});
      tick();
      e = px_q.pop_front();
      tests++;
      if (pixel_valid !== e.valid || pixel_data !== e.data) begin
        fails++;
        $display("[TB] FAIL row2_pixel x=%0d: got %b/%h, required %b/%h",
                 x_addr, pixel_valid, pixel_data, e.valid, e.data);
      end
    end
  endtask

  task automatic test_abort();
    px_t e;
    y_addr = 10'd9; row_req = 1'b1; tick();
    row_req = 1'b0;
    tick(); tick();
    state = 8'h02; tick();
    tests++;
    if (row_busy !== 1'b0 || image_complete !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_leave: got busy=%b complete=%b, required 0/1",
               row_busy, image_complete);
    end
    x_addr = 10'(STARTCOL); y_addr = 10'd12;
    px_q.push_back('{valid: 1'b1, data: PIX_W'(2*W + 1)});
    tick();
    e = px_q.pop_front();
    tests++;
    if (pixel_valid !== e.valid || pixel_data !== e.data) begin
      fails++;
      $display("[TB] FAIL abort_no_swap: got %b/%h, required %b/%h",
               pixel_valid, pixel_data, e.valid, e.data);
    end
    state = 8'h03; tick();
    y_addr = 10'd9; row_req = 1'b1; tick();
    row_req = 1'b0;
    tests++;
    if (row_busy !== 1'b1) begin
      fails++; $display("[TB] FAIL refill_start: got row_busy=%b, required 1", row_busy);
    end
    tick();
    state = 8'h01; tick();
    tests++;
    if (row_busy !== 1'b0 || image_complete !== 1'b0 || err_overflow !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_abort: got busy=%b complete=%b err=%b, required 0/0/0",
               row_busy, image_complete, err_overflow);
    end
    y_addr = 10'd12;
    px_q.push_back('{valid: 1'b0, data: BG});
    tick();
    e = px_q.pop_front();
    tests++;
    if (pixel_valid !== e.valid || pixel_data !== e.data) begin
      fails++;
      $display("[TB] FAIL idle_pixel: got %b/%h, required %b/%h",
               pixel_valid, pixel_data, e.valid, e.data);
    end
  endtask

  task automatic test_reset_mid_recv();
    state = 8'h02; tick();
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = PIX_W'(12'h0A1 + i);
      wr_q.push_back('{addr: AW'(i), data: PIX_W'(12'h0A1 + i)});
      tick();
    end
    bus.rx_data = 12'h0A4; rst = 1'b1;
    tick();
    tests++;
    if ({bus.rx_ready, bus.spram_wre, row_busy, image_receiving, image_complete,
         err_overflow, pixel_valid} !== 7'b0 || pixel_data !== BG ||
        bus.spram_addr !== '0 || bus.spram_wr_data !== '0) begin
      fails++;
      $display("[TB] FAIL rst_mid_recv: got flags=%b pix=%h addr=%0d data=%h, required 0/%h/0/0",
               {bus.rx_ready, bus.spram_wre, row_busy, image_receiving, image_complete,
                err_overflow, pixel_valid}, pixel_data, bus.spram_addr, bus.spram_wr_data, BG);
    end
    rst = 1'b0; bus.rx_valid = 1'b0;
    state = 8'h03; y_addr = 10'd10; row_req = 1'b1; tick();
    row_req = 1'b0;
    tests++;
    if (row_busy !== 1'b0 || wr_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL disp_before_complete: got busy=%b pending_writes=%0d, required 0/0",
               row_busy, wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_overflow();
    test_fill();
    test_out_of_range();
    test_busy_ignore();
    test_abort();
    test_reset_mid_recv();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
